vga_sync_gen: RTL and testbench

- Generates the VGA raster timing (pixel position, hsync, vsync, blanking) that drives every draw_* block in the snake display path.
- x_pos/y_pos feed the border, grid and snake renderers.
- hsync/vsync/display_on go to the output mux alongside their rgb.
- Default timing is 640x480@60 Hz, with one pixel per clock-enable tick.

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_axis_counter.sv | 60 ++++++
 rtl/vga_sync_gen.sv | 108 ++++++++++
 tb/tb_vga_sync_gen.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants (640x480@60 defaults) used by the sync
// generator and the draw_* renderers.
package vga_timing_pkg;

  localparam int unsigned DEF_POS_BIT   = 10;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;

  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam logic        DEF_SYNC_POL  = 1'b0;

  // Full period of one axis: visible + front porch + sync + back porch.
  function automatic int unsigned axis_total(input int unsigned display,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return display + front + sync + back;
  endfunction

  localparam int unsigned DEF_H_TOTAL =
    axis_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int unsigned DEF_V_TOTAL =
    axis_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus decode of the next position
// into active-area and sync levels.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned BIT      = DEF_POS_BIT,
  parameter int unsigned DISPLAY  = DEF_H_DISPLAY,
  parameter int unsigned FRONT    = DEF_H_FRONT,
  parameter int unsigned SYNC     = DEF_H_SYNC,
  parameter int unsigned BACK     = DEF_H_BACK,
  parameter logic        SYNC_POL = DEF_SYNC_POL
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           step,
  output logic [BIT-1:0] count,
  output logic           wrap_c,
  output logic           active_next_c,
  output logic           sync_next_c
);

  localparam int unsigned TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);

  localparam logic [BIT-1:0] LAST       = BIT'(TOTAL - 1);
  localparam logic [BIT-1:0] DISP_END   = BIT'(DISPLAY);
  localparam logic [BIT-1:0] SYNC_FIRST = BIT'(DISPLAY + FRONT);
  localparam logic [BIT-1:0] SYNC_LAST  = BIT'(DISPLAY + FRONT + SYNC - 1);

  logic [BIT-1:0] next_count_c;

  // Next position; reset has priority so the decode below reflects (0) too.
  always_comb begin
    wrap_c       = step & (count == LAST);
    next_count_c = count;
    if (reset) begin
      next_count_c = '0;
    end else if (step) begin
      next_count_c = wrap_c ? '0 : count + BIT'(1);
    end
  end

  // Decode is taken from the next position so registered outputs line up
  // with the counter value they are loaded alongside.
  always_comb begin
    active_next_c = (next_count_c < DISP_END);
    sync_next_c   = ~SYNC_POL;
    if ((next_count_c >= SYNC_FIRST) && (next_count_c <= SYNC_LAST)) begin
      sync_next_c = SYNC_POL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= next_count_c;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel position, hsync/vsync, blanking and
// line/frame start pulses. Define VGA_SYNC_FRAME_CNT_EN to add frame_cnt.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned BIT       = DEF_POS_BIT,
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter logic        SYNC_POL  = DEF_SYNC_POL
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ce,
  output logic [BIT-1:0] x_pos,
  output logic [BIT-1:0] y_pos,
  output logic           display_on,
  output logic           hsync,
  output logic           vsync,
  output logic           line_start,
  output logic           frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0]     frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  logic h_wrap_c;
  logic h_active_next_c;
  logic h_sync_next_c;
  logic v_step_c;
  logic v_wrap_c;
  logic v_active_next_c;
  logic v_sync_next_c;

  assign v_step_c = ce & h_wrap_c;

  vga_axis_counter #(
    .BIT      (BIT),
    .DISPLAY  (H_DISPLAY),
    .FRONT    (H_FRONT),
    .SYNC     (H_SYNC),
    .BACK     (H_BACK),
    .SYNC_POL (SYNC_POL)
  ) u_h_axis (
    .clk           (clk),
    .reset         (reset),
    .step          (ce),
    .count         (x_pos),
    .wrap_c        (h_wrap_c),
    .active_next_c (h_active_next_c),
    .sync_next_c   (h_sync_next_c)
  );

  vga_axis_counter #(
    .BIT      (BIT),
    .DISPLAY  (V_DISPLAY),
    .FRONT    (V_FRONT),
    .SYNC     (V_SYNC),
    .BACK     (V_BACK),
    .SYNC_POL (SYNC_POL)
  ) u_v_axis (
    .clk           (clk),
    .reset         (reset),
    .step          (v_step_c),
    .count         (y_pos),
    .wrap_c        (v_wrap_c),
    .active_next_c (v_active_next_c),
    .sync_next_c   (v_sync_next_c)
  );

  // Level outputs track the counters with zero latency; pulses last one clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      display_on  <= 1'b1;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      display_on  <= h_active_next_c & v_active_next_c;
      hsync       <= h_sync_next_c;
      vsync       <= v_sync_next_c;
      line_start  <= h_wrap_c;
      frame_start <= v_wrap_c;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  // Game-tick source: counts frames, wrapping at 256.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= 8'd0;
    end else if (v_wrap_c) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen using a reduced raster so whole frames
// fit in a short run; the model derives position from an enabled-tick count.
module tb_vga_sync_gen;

  localparam int unsigned BIT = 10;
  localparam int unsigned HD = 10, HF = 2, HS = 3, HB = 4;
  localparam int unsigned VD = 6,  VF = 1, VS = 2, VB = 3;
  localparam int unsigned HT = HD + HF + HS + HB;
  localparam int unsigned VT = VD + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam logic POL = 1'b0;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           ce = 1'b0;
  logic [BIT-1:0] x_pos;
  logic [BIT-1:0] y_pos;
  logic           display_on;
  logic           hsync;
  logic           vsync;
  logic           line_start;
  logic           frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0]     frame_cnt;
`endif

  vga_sync_gen #(
    .BIT(BIT),
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(POL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .display_on  (display_on),
    .hsync       (hsync),
    .vsync       (vsync),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int   x;
    int   y;
    logic disp;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
    int   fc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   tests = 0;
  int   fails = 0;
  int   t = 0;          // enabled ticks since frame origin, 0..FRAME-1
  int   fc_m = 0;
  int   fs_exp = 0;
  int   fs_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and queue the state expected after the edge.
  task automatic drive(input logic c, input logic r);
    exp_t e;
    @(negedge clk);
    ce = c;
    reset = r;
    e.ls = 1'b0;
    e.fs = 1'b0;
    if (r) begin
      t = 0;
      fc_m = 0;
    end else if (c) begin
      t = (t + 1) % FRAME;
      e.ls = ((t % HT) == 0);
      e.fs = (t == 0);
    end
    if (e.fs) begin
      fc_m = (fc_m + 1) % 256;
      fs_exp++;
    end
    e.x    = t % HT;
    e.y    = t / HT;
    e.disp = (e.x < HD) && (e.y < VD);
    e.hs   = (e.x >= HD + HF && e.x < HD + HF + HS) ? POL : ~POL;
    e.vs   = (e.y >= VD + VF && e.y < VD + VF + VS) ? POL : ~POL;
    e.fc   = fc_m;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m_e = q.pop_front();
      chk("x_pos", 32'(x_pos), 32'(m_e.x));
      chk("y_pos", 32'(y_pos), 32'(m_e.y));
      chk("display_on", 32'(display_on), 32'(m_e.disp));
      chk("hsync", 32'(hsync), 32'(m_e.hs));
      chk("vsync", 32'(vsync), 32'(m_e.vs));
      chk("line_start", 32'(line_start), 32'(m_e.ls));
      chk("frame_start", 32'(frame_start), 32'(m_e.fs));
`ifdef VGA_SYNC_FRAME_CNT_EN
      chk("frame_cnt", 32'(frame_cnt), 32'(m_e.fc));
`endif
      if (frame_start === 1'b1) fs_seen++;
    end
  end

  initial begin
    // Reset overrides ce, then one full frame plus a little with ce held high.
    drive(1'b1, 1'b1);
    repeat (FRAME + HT + 3) drive(1'b1, 1'b0);

    // ce at half rate across a full frame.
    repeat (FRAME + 5) begin
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
    end

    // Mid-frame reset with ce low, then resume.
    for (int i = 0; i < FRAME && t != 3 * HT + 7; i++) drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);

    // Random ce with occasional resets.
    repeat (4 * FRAME) drive($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);

`ifdef VGA_SYNC_FRAME_CNT_EN
    // Enough frames to carry frame_cnt through its 255 -> 0 wrap.
    drive(1'b0, 1'b1);
    repeat (257 * FRAME) drive(1'b1, 1'b0);
`endif

    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("frame_start_count", 32'(fs_seen), 32'(fs_exp));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
